// File: rtl/alu_op_sequencer.sv
// Keystroke-driven ALU sequencer: collects A, B, opcode and carry-in from decoded keys,
// issues the operation, waits a settle time, captures the result and steers the display.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  input  logic [3:0] alu_out,
  input  logic       alu_cout,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  output logic       alu_mode,
  output logic       alu_cin,
  output logic [3:0] result,
  output logic       result_cout,
  output logic       disp_sel,
  output logic [4:0] disp_digit,
  output logic       busy,
  output logic       done
);

  // state | meaning
  // S_A   | waiting for operand A digit
  // S_B   | waiting for operand B digit
  // S_OP  | collecting opcode digit(s), ENTER issues once one is seen
  // EXEC  | ALU settling for SETTLE_CYCLES cycles
  // CAP   | single cycle; result captured on its closing edge
  // SHOW  | result displayed until the next key
  typedef enum logic [2:0] {S_A, S_B, S_OP, EXEC, CAP, SHOW} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d, opcode_q, opcode_d;
  logic       op_valid_q, op_valid_d, cin_q, cin_d;
  logic [3:0] result_q, result_d;
  logic       result_cout_q, result_cout_d;
  logic       disp_sel_q, disp_sel_d;
  logic [4:0] disp_digit_q, disp_digit_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic [3:0] cnt_q, cnt_d;

  logic key_digit, key_enter, key_clear, key_cin;

  assign key_digit = key_valid && (key_code[4] == 1'b0);
  assign key_enter = key_valid && (key_code == 5'h10);
  assign key_clear = key_valid && (key_code == 5'h11);
  assign key_cin   = key_valid && (key_code == 5'h12);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q       <= S_A;
      a_q           <= '0;
      b_q           <= '0;
      opcode_q      <= '0;
      op_valid_q    <= 1'b0;
      cin_q         <= 1'b0;
      result_q      <= '0;
      result_cout_q <= 1'b0;
      disp_sel_q    <= 1'b0;
      disp_digit_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      opcode_q      <= opcode_d;
      op_valid_q    <= op_valid_d;
      cin_q         <= cin_d;
      result_q      <= result_d;
      result_cout_q <= result_cout_d;
      disp_sel_q    <= disp_sel_d;
      disp_digit_q  <= disp_digit_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    opcode_d      = opcode_q;
    op_valid_d    = op_valid_q;
    cin_d         = cin_q;
    result_d      = result_q;
    result_cout_d = result_cout_q;
    disp_sel_d    = disp_sel_q;
    disp_digit_d  = disp_digit_q;
    done_d        = 1'b0;
    cnt_d         = cnt_q;

    if (key_clear) begin
      // result registers deliberately survive a CLEAR
      state_d      = S_A;
      a_d          = '0;
      b_d          = '0;
      opcode_d     = '0;
      op_valid_d   = 1'b0;
      cin_d        = 1'b0;
      disp_sel_d   = 1'b0;
      disp_digit_d = '0;
      cnt_d        = '0;
    end else begin
      case (state_q)
        S_A: begin
          if (key_digit) begin
            a_d          = key_code[3:0];
            disp_digit_d = {1'b0, key_code[3:0]};
            state_d      = S_B;
          end else if (key_cin) begin
            cin_d = ~cin_q;
          end
        end
        S_B: begin
          if (key_digit) begin
            b_d          = key_code[3:0];
            disp_digit_d = {1'b0, key_code[3:0]};
            state_d      = S_OP;
          end else if (key_cin) begin
            cin_d = ~cin_q;
          end
        end
        S_OP: begin
          if (key_digit) begin
            opcode_d     = key_code[3:0];
            op_valid_d   = 1'b1;
            disp_digit_d = {1'b0, key_code[3:0]};
          end else if (key_enter && op_valid_q) begin
            state_d = EXEC;
            cnt_d   = CNT_LOAD;
          end else if (key_cin) begin
            cin_d = ~cin_q;
          end
        end
        EXEC: begin
          if (cnt_q == 4'd0) state_d = CAP;
          else               cnt_d   = cnt_q - 4'd1;
        end
        CAP: begin
          result_d      = alu_out;
          result_cout_d = alu_cout;
          done_d        = 1'b1;
          disp_sel_d    = 1'b1;
          disp_digit_d  = {alu_cout, alu_out};
          state_d       = SHOW;
        end
        SHOW: begin
          if (key_digit) begin
            a_d          = key_code[3:0];
            op_valid_d   = 1'b0;
            disp_sel_d   = 1'b0;
            disp_digit_d = {1'b0, key_code[3:0]};
            state_d      = S_B;
          end else if (key_enter) begin
            state_d = EXEC;
            cnt_d   = CNT_LOAD;
          end else if (key_cin) begin
            cin_d = ~cin_q;
          end
        end
        default: state_d = S_A;
      endcase
    end

    busy_d = (state_d == EXEC) || (state_d == CAP);
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = opcode_q[2:0];
  assign alu_mode    = opcode_q[3];
  assign alu_cin     = cin_q;
  assign result      = result_q;
  assign result_cout = result_cout_q;
  assign disp_sel    = disp_sel_q;
  assign disp_digit  = disp_digit_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed key scenarios plus random key streams,
// compared every cycle against a transaction-level model of the sequencer.
module tb_alu_op_sequencer;

  localparam int SETTLE = 2;

  logic       CLK100MHZ = 1'b0;
  logic       CPU_RESETN = 1'b0;
  logic       key_valid = 1'b0;
  logic [4:0] key_code = '0;
  logic [3:0] alu_out;
  logic       alu_cout;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic       alu_mode, alu_cin;
  logic [3:0] result;
  logic       result_cout, disp_sel;
  logic [4:0] disp_digit;
  logic       busy, done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK100MHZ = ~CLK100MHZ;

  // ALU stand-in: plain 4-bit add, carry out of bit 3
  logic [4:0] alu_sum;
  assign alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_out  = alu_sum[3:0];
  assign alu_cout = alu_sum[4];

  alu_op_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN),
    .key_valid(key_valid), .key_code(key_code),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_mode(alu_mode),
    .alu_cin(alu_cin), .result(result), .result_cout(result_cout),
    .disp_sel(disp_sel), .disp_digit(disp_digit), .busy(busy), .done(done)
  );

  // reference model: where we are in the transaction, plus a settle countdown
  localparam int P_A = 0, P_B = 1, P_OP = 2, P_RUN = 3, P_SHOW = 4;
  int         m_phase;
  int         m_left;
  logic [3:0] m_a, m_b, m_opc, m_res;
  logic       m_opv, m_cin, m_cout, m_dsel, m_done;
  logic [4:0] m_ddig;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_A; m_left = 0;
    m_a = '0; m_b = '0; m_opc = '0; m_res = '0;
    m_opv = 1'b0; m_cin = 1'b0; m_cout = 1'b0; m_dsel = 1'b0; m_done = 1'b0;
    m_ddig = '0;
  endtask

  task automatic model_step(input logic kv, input logic [4:0] kc);
    int sum;
    m_done = 1'b0;
    if (kv && kc == 5'h11) begin
      m_phase = P_A; m_left = 0;
      m_a = '0; m_b = '0; m_opc = '0; m_opv = 1'b0; m_cin = 1'b0;
      m_dsel = 1'b0; m_ddig = '0;
    end else if (m_phase == P_RUN) begin
      m_left--;
      if (m_left == 0) begin
        sum    = int'(m_a) + int'(m_b);
        m_res  = 4'(sum % 16);
        m_cout = (sum >= 16);
        m_done = 1'b1;
        m_dsel = 1'b1;
        m_ddig = {m_cout, m_res};
        m_phase = P_SHOW;
      end
    end else if (kv) begin
      if (kc < 5'h10) begin
        case (m_phase)
          P_A:    begin m_a = kc[3:0]; m_phase = P_B; end
          P_B:    begin m_b = kc[3:0]; m_phase = P_OP; end
          P_OP:   begin m_opc = kc[3:0]; m_opv = 1'b1; end
          default: begin m_a = kc[3:0]; m_opv = 1'b0; m_dsel = 1'b0; m_phase = P_B; end
        endcase
        m_ddig = {1'b0, kc[3:0]};
      end else if (kc == 5'h10) begin
        if ((m_phase == P_OP && m_opv) || m_phase == P_SHOW) begin
          m_phase = P_RUN;
          m_left  = SETTLE + 1;
        end
      end else if (kc == 5'h12) begin
        m_cin = ~m_cin;
      end
    end
  endtask

  task automatic check_all();
    check("alu_a",       8'(alu_a),       8'(m_a));
    check("alu_b",       8'(alu_b),       8'(m_b));
    check("alu_op",      8'(alu_op),      8'(m_opc[2:0]));
    check("alu_mode",    8'(alu_mode),    8'(m_opc[3]));
    check("alu_cin",     8'(alu_cin),     8'(m_cin));
    check("result",      8'(result),      8'(m_res));
    check("result_cout", 8'(result_cout), 8'(m_cout));
    check("disp_sel",    8'(disp_sel),    8'(m_dsel));
    check("disp_digit",  8'(disp_digit),  8'(m_ddig));
    check("busy",        8'(busy),        8'(m_phase == P_RUN));
    check("done",        8'(done),        8'(m_done));
  endtask

  // one clock with the given key presented; inputs change and outputs are sampled on negedge
  task automatic cyc(input logic kv, input logic [4:0] kc);
    key_valid = kv;
    key_code  = kc;
    @(posedge CLK100MHZ);
    model_step(kv, kc);
    @(negedge CLK100MHZ);
    key_valid = 1'b0;
    key_code  = '0;
    check_all();
  endtask

  task automatic key(input logic [4:0] kc);
    cyc(1'b1, kc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'h00);
  endtask

  int done_cnt;
  int busy_cnt;

  initial begin
    model_reset();
    CPU_RESETN = 1'b0;
    repeat (2) @(negedge CLK100MHZ);
    check_all();
    CPU_RESETN = 1'b1;
    idle(1);

    // 3 + 5, opcode 0
    key(5'h03); key(5'h05); key(5'h00);
    busy_cnt = 0; done_cnt = 0;
    key(5'h10);
    if (busy) busy_cnt++;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    check("s1_busy_cycles", 8'(busy_cnt), 8'(SETTLE + 1));
    check("s1_done_pulses", 8'(done_cnt), 8'd1);
    check("s1_disp", 8'(disp_digit), 8'h08);

    // F + 2 with opcode 9 (from SHOW, F becomes A)
    key(5'h0F); key(5'h02); key(5'h09);
    check("s2_op", 8'({alu_mode, alu_op}), 8'h09);
    key(5'h10); idle(SETTLE + 2);
    check("s2_disp", 8'(disp_digit), 8'h11);

    // ENTER without an opcode is ignored
    key(5'h11); key(5'h04); key(5'h04);
    busy_cnt = 0;
    key(5'h10); if (busy) busy_cnt++;
    key(5'h10); if (busy) busy_cnt++;
    idle(3);    if (busy) busy_cnt++;
    check("s3_never_busy", 8'(busy_cnt), 8'd0);

    // CLEAR during EXEC aborts, result survives
    key(5'h00); key(5'h10); idle(1);
    key(5'h11);
    check("s4_result_kept", 8'({result_cout, result}), 8'h11);
    idle(4);

    // CIN toggle and re-execute from SHOW, then a digit restarts entry
    key(5'h03); key(5'h05); key(5'h00); key(5'h10); idle(SETTLE + 2);
    key(5'h12);
    check("s5_cin", 8'(alu_cin), 8'd1);
    done_cnt = 0;
    key(5'h10);
    for (int i = 0; i < SETTLE + 2; i++) begin
      idle(1);
      if (done) done_cnt++;
    end
    check("s5_second_done", 8'(done_cnt), 8'd1);
    key(5'h07);
    check("s5_disp_sel", 8'(disp_sel), 8'd0);

    // asynchronous reset while collecting the opcode
    key(5'h11); key(5'h01); key(5'h02); key(5'h03);
    #2 CPU_RESETN = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    idle(1);

    // random key streams, CLEAR kept rare so operations complete
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] kc;
      kc = 5'($urandom_range(0, 31));
      if (kc == 5'h11 && ($urandom_range(0, 7) != 0)) kc = 5'h10;
      if ($urandom_range(0, 9) < 3) kc = 5'h10;
      cyc(($urandom_range(0, 2) == 0), kc);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
